pwm_fade_ctrl: RTL and testbench

Sequencer that configures pwm_driver so brightness fades to a target duty level instead of jumping there.
- Accepts a fade command (target level, step size) on a valid/ready handshake.
- Walks the level toward the target one step at a time, holding each step for DWELL_CYCLES clocks.
- Each new level goes to the driver as a one-cycle set_cutoff_en pulse with cutoff_value.
- Sits between the control/register logic and pwm_driver, in the same clock domain.

---
 rtl/pwm_ctrl_pkg.sv | 34 +++
 rtl/dwell_timer.sv | 34 +++
 rtl/pwm_fade_ctrl.sv | 143 ++++++++++++++
 tb/tb_pwm_fade_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_ctrl_pkg.sv
// Shared types and constants for the PWM fade controller and pwm_driver.
package pwm_ctrl_pkg;

    typedef logic [7:0] level_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        STEP  = 2'd2
    } fade_state_t;

    // Must match pwm_driver's reset cutoff so a reset needs no write.
    localparam level_t PWM_RESET_LEVEL = 8'h7f;

    // One fade step toward target, clamped so the level never overshoots.
    // Arithmetic is 9 bits wide so a large step cannot wrap past 8'hff or 0.
    function automatic level_t fade_next_level(input level_t level,
                                               input level_t step,
                                               input level_t target,
                                               input logic   up);
        logic [8:0] sum;
        logic [8:0] diff;
        level_t     res;
        sum  = {1'b0, level} + {1'b0, step};
        diff = {1'b0, level} - {1'b0, step};
        if (up) begin
            res = (sum >= {1'b0, target}) ? target : sum[7:0];
        end else begin
            res = (diff[8] || (diff[7:0] <= target)) ? target : diff[7:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// 16-bit down counter with synchronous load and a zero flag.
module dwell_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] load_value,
    input  logic        en,
    output logic        zero
);

    logic [15:0] count_q, count_d;

    // Load has priority; otherwise count down while enabled, stopping at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - 16'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Fade sequencer for pwm_driver: walks the cutoff level toward a commanded
// target one step per DWELL_CYCLES+1 clocks, issuing a one-cycle load strobe
// per step. Optional abort input is enabled by defining PWM_FADE_ABORT_EN.
module pwm_fade_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter logic [15:0] DWELL_CYCLES = 16'd1000,
    parameter level_t      RESET_LEVEL  = PWM_RESET_LEVEL
) (
    input  logic       clk,
    input  logic       reset,
`ifdef PWM_FADE_ABORT_EN
    input  logic       abort,
`endif
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_target,
    input  logic [7:0] cmd_step,
    output logic       set_cutoff_en,
    output logic [7:0] cutoff_value,
    output logic       busy,
    output logic       done
);

    fade_state_t state_q, state_d;
    level_t      level_q, level_d;
    level_t      target_q, target_d;
    level_t      step_q, step_d;
    logic        up_q, up_d;
    level_t      cutoff_q, cutoff_d;
    logic        strobe_q, strobe_d;
    logic        done_q, done_d;
    logic        tmr_load, tmr_en, tmr_zero;
    logic        abort_w;

`ifdef PWM_FADE_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    dwell_timer u_dwell_timer (
        .clk        (clk),
        .rst        (reset),
        .load       (tmr_load),
        .load_value (DWELL_CYCLES - 16'd1),
        .en         (tmr_en),
        .zero       (tmr_zero)
    );

    assign cmd_ready = (state_q == IDLE) && !reset;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign cutoff_value = cutoff_q;

    // The new level is registered on entry to STEP so the strobe and value
    // are flop outputs; level_q commits on leaving STEP, which lets an abort
    // during STEP suppress both the strobe and the level update.
`ifdef PWM_FADE_ABORT_EN
    assign set_cutoff_en = strobe_q && !abort;
`else
    assign set_cutoff_en = strobe_q;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        target_d = target_q;
        step_d   = step_q;
        up_d     = up_q;
        cutoff_d = cutoff_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (cmd_target == level_q) begin
                        done_d = 1'b1;
                    end else begin
                        target_d = cmd_target;
                        step_d   = (cmd_step == '0) ? 8'd1 : cmd_step;
                        up_d     = (cmd_target > level_q);
                        tmr_load = 1'b1;
                        state_d  = DWELL;
                    end
                end
            end
            DWELL: begin
                tmr_en = 1'b1;
                if (abort_w) begin
                    state_d = IDLE;
                end else if (tmr_zero) begin
                    cutoff_d = fade_next_level(level_q, step_q, target_q, up_q);
                    strobe_d = 1'b1;
                    state_d  = STEP;
                end
            end
            STEP: begin
                if (abort_w) begin
                    cutoff_d = level_q;
                    state_d  = IDLE;
                end else begin
                    level_d = cutoff_q;
                    if (cutoff_q == target_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        tmr_load = 1'b1;
                        state_d  = DWELL;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            level_q  <= RESET_LEVEL;
            target_q <= RESET_LEVEL;
            step_q   <= 8'd1;
            up_q     <= 1'b0;
            cutoff_q <= RESET_LEVEL;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            target_q <= target_d;
            step_q   <= step_d;
            up_q     <= up_d;
            cutoff_q <= cutoff_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed testbench for pwm_fade_ctrl with DWELL_CYCLES=4.
module tb_pwm_fade_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       abort;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_target;
    logic [7:0] cmd_step;
    logic       set_cutoff_en;
    logic [7:0] cutoff_value;
    logic       busy;
    logic       done;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] sv_q[$];
    int         sc_q[$];
    int         done_at;
    logic       busy1;

    always #5 clk = ~clk;

    pwm_fade_ctrl #(.DWELL_CYCLES(16'd4)) dut (
        .clk           (clk),
        .reset         (reset),
`ifdef PWM_FADE_ABORT_EN
        .abort         (abort),
`endif
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_target    (cmd_target),
        .cmd_step      (cmd_step),
        .set_cutoff_en (set_cutoff_en),
        .cutoff_value  (cutoff_value),
        .busy          (busy),
        .done          (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a command at a falling edge; it is accepted at the next rising edge (N).
    task automatic issue(input logic [7:0] tgt, input logic [7:0] stp);
        @(negedge clk);
        check("ready_before_cmd", cmd_ready, 1);
        cmd_target = tgt;
        cmd_step   = stp;
        cmd_valid  = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Record strobes (value, cycle offset from N) until done or budget expires.
    task automatic collect(input int budget);
        sv_q.delete();
        sc_q.delete();
        done_at = -1;
        busy1 = 1'bx;
        for (int k = 1; k <= budget && done_at < 0; k++) begin
            @(negedge clk);
            if (k == 1) busy1 = busy;
            if (set_cutoff_en) begin
                sv_q.push_back(cutoff_value);
                sc_q.push_back(k);
            end
            if (done) begin
                done_at = k;
                check("ready_at_done", cmd_ready, 1);
                check("done_strobe_excl", set_cutoff_en, 0);
            end
        end
        check("done_within_budget", (done_at > 0), 1);
    endtask

    initial begin
        int s;
        reset      = 1'b1;
        abort      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_target = '0;
        cmd_step   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_strobe", set_cutoff_en, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_cutoff", cutoff_value, 8'h7f);
        @(negedge clk) reset = 1'b0;
        #1 check("ready_after_rst", cmd_ready, 1);

        // No-op: target equals reset level.
        issue(8'h7f, 8'd3);
        collect(10);
        check("noop_busy", busy1, 0);
        check("noop_strobes", sv_q.size(), 0);
        check("noop_done_cycle", done_at, 1);

        // 7f -> 83 step 2: 81 @5, 83 @10, done @11.
        issue(8'h83, 8'd2);
        collect(40);
        check("up_busy", busy1, 1);
        check("up_count", sv_q.size(), 2);
        if (sv_q.size() == 2) begin
            check("up_v0", sv_q[0], 8'h81);
            check("up_v1", sv_q[1], 8'h83);
            check("up_c0", sc_q[0], 5);
            check("up_c1", sc_q[1], 10);
        end
        check("up_done_cycle", done_at, 11);

        // 83 -> 7f step 4: single strobe 7f @5.
        issue(8'h7f, 8'd4);
        collect(40);
        check("back_count", sv_q.size(), 1);
        if (sv_q.size() == 1) check("back_v0", sv_q[0], 8'h7f);
        check("back_done_cycle", done_at, 6);

        // 7f -> 00 step 50: 2f then clamped 00, no wrap.
        issue(8'h00, 8'h50);
        collect(40);
        check("down_count", sv_q.size(), 2);
        if (sv_q.size() == 2) begin
            check("down_v0", sv_q[0], 8'h2f);
            check("down_v1", sv_q[1], 8'h00);
        end
        check("down_done_cycle", done_at, 11);

        // 00 -> f0 step ff: clamped at f0 in one step.
        issue(8'hf0, 8'hff);
        collect(40);
        check("clamp_up_count", sv_q.size(), 1);
        if (sv_q.size() == 1) check("clamp_up_v0", sv_q[0], 8'hf0);

        // f0 -> ff step 0 (treated as 1): 15 strobes, last ff @75, done @76.
        issue(8'hff, 8'h00);
        collect(120);
        check("step0_count", sv_q.size(), 15);
        if (sv_q.size() == 15) begin
            check("step0_first", sv_q[0], 8'hf1);
            check("step0_last", sv_q[14], 8'hff);
            check("step0_last_cycle", sc_q[14], 75);
        end
        check("step0_done_cycle", done_at, 76);

        // Reset during second DWELL of ff -> 00 step 1.
        issue(8'h00, 8'd1);
        s = 0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (set_cutoff_en) s++;
        end
        check("pre_rst_strobes", s, 1);
        #2 reset = 1'b1;
        #1;
        check("arst_strobe", set_cutoff_en, 0);
        check("arst_done", done, 0);
        check("arst_busy", busy, 0);
        check("arst_cutoff", cutoff_value, 8'h7f);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        s = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (set_cutoff_en || done || busy) s++;
        end
        check("post_rst_quiet", s, 0);
        issue(8'h81, 8'd1);
        collect(40);
        check("post_rst_count", sv_q.size(), 2);
        if (sv_q.size() == 2) begin
            check("post_rst_v0", sv_q[0], 8'h80);
            check("post_rst_v1", sv_q[1], 8'h81);
        end
        check("post_rst_done_cycle", done_at, 11);

`ifdef PWM_FADE_ABORT_EN
        // 81 -> 91 step 4: strobe 85 @5, abort in DWELL at cycle 7.
        issue(8'h91, 8'd4);
        s = 0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (set_cutoff_en) s++;
        end
        check("abort_pre_strobes", s, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_ready", cmd_ready, 1);
        s = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done || set_cutoff_en) s++;
        end
        check("abort_no_done", s, 0);
        // From last written 85: 89 in one step.
        issue(8'h89, 8'd4);
        collect(40);
        check("abort_resume_count", sv_q.size(), 1);
        if (sv_q.size() == 1) check("abort_resume_v0", sv_q[0], 8'h89);
        check("abort_resume_done", done_at, 6);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
